// File: rtl/food_place_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : food_place_ctrl
// Description : Places the snake food box. On an eat event it samples the
//               free-running LFSR twice to build a grid-aligned (x,y)
//               candidate, bounds-checks it, asks the body tracker whether
//               the cell is occupied, and commits a free candidate. Too many
//               rejections fall back to a fixed default position.
// Ports       : clk, rst_n          - clock, async active-low reset
//               eat                 - snake head reached the food (level)
//               rand_num[8:0]       - LFSR value, advances every clock
//               occ_req/occ_x/occ_y - occupancy query, held until occ_ack
//               occ_ack/occ_hit     - query answer (hit = cell occupied)
//               food_x/food_y       - committed food position
//               food_valid          - position usable by the renderer
//               busy                - placement in progress
//               done/fail           - commit pulse / fallback-used pulse
// Revision    : 1.0 - initial release
// ============================================================================
module food_place_ctrl #(
  parameter int unsigned X_MIN      = 8,
  parameter int unsigned X_MAX      = 624,
  parameter int unsigned Y_MIN      = 8,
  parameter int unsigned Y_MAX      = 464,
  parameter int unsigned GRID_SHIFT = 3,
  parameter int unsigned MAX_TRY    = 31,
  parameter int unsigned DEF_X      = 304,
  parameter int unsigned DEF_Y      = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       eat,
  input  logic [8:0] rand_num,
  output logic       occ_req,
  output logic [9:0] occ_x,
  output logic [8:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic [9:0] food_x,
  output logic [8:0] food_y,
  output logic       food_valid,
  output logic       busy,
  output logic       done,
  output logic       fail
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SX   = 3'd1,
    ST_SY   = 3'd2,
    ST_CHK  = 3'd3,
    ST_QRY  = 3'd4
  } state_t;

  localparam logic [9:0] c_x_min   = 10'(X_MIN);
  localparam logic [9:0] c_x_max   = 10'(X_MAX);
  localparam logic [8:0] c_y_min   = 9'(Y_MIN);
  localparam logic [8:0] c_y_max   = 9'(Y_MAX);
  localparam logic [9:0] c_def_x   = 10'(DEF_X);
  localparam logic [8:0] c_def_y   = 9'(DEF_Y);
  localparam logic [4:0] c_max_try = 5'(MAX_TRY);
  // Masks that clear the sub-grid bits of a candidate.
  localparam logic [9:0] c_x_mask  = 10'h3FF << GRID_SHIFT;
  localparam logic [8:0] c_y_mask  = 9'h1FF << GRID_SHIFT;

  state_t     state_q, state_d;
  logic [9:0] x_cand_q, x_cand_d;
  logic [8:0] y_cand_q, y_cand_d;
  logic [4:0] try_q, try_d;
  logic       occ_req_q, occ_req_d;
  logic [9:0] occ_x_q, occ_x_d;
  logic [8:0] occ_y_q, occ_y_d;
  logic [9:0] food_x_q, food_x_d;
  logic [8:0] food_y_q, food_y_d;
  logic       food_valid_q, food_valid_d;
  logic       done_q, done_d;
  logic       fail_q, fail_d;

  logic       w_in_bounds;
  logic       w_retry;

  assign w_in_bounds = (x_cand_q >= c_x_min) && (x_cand_q <= c_x_max) &&
                       (y_cand_q >= c_y_min) && (y_cand_q <= c_y_max);

  always_comb begin
    state_d      = state_q;
    x_cand_d     = x_cand_q;
    y_cand_d     = y_cand_q;
    try_d        = try_q;
    occ_req_d    = occ_req_q;
    occ_x_d      = occ_x_q;
    occ_y_d      = occ_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    done_d       = 1'b0;
    fail_d       = 1'b0;
    w_retry      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (eat) begin
          state_d      = ST_SX;
          food_valid_d = 1'b0;
          try_d        = '0;
        end
      end
      ST_SX: begin
        // x spans 0..1022 from a 9-bit sample, so double it before snapping.
        x_cand_d = {rand_num, 1'b0} & c_x_mask;
        state_d  = ST_SY;
      end
      ST_SY: begin
        y_cand_d = rand_num & c_y_mask;
        state_d  = ST_CHK;
      end
      ST_CHK: begin
        if (w_in_bounds) begin
          occ_x_d   = x_cand_q;
          occ_y_d   = y_cand_q;
          occ_req_d = 1'b1;
          state_d   = ST_QRY;
        end else begin
          w_retry = 1'b1;
        end
      end
      ST_QRY: begin
        if (occ_ack) begin
          occ_req_d = 1'b0;
          if (occ_hit) begin
            w_retry = 1'b1;
          end else begin
            food_x_d     = x_cand_q;
            food_y_d     = y_cand_q;
            food_valid_d = 1'b1;
            done_d       = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Shared by bounds rejects and occupancy hits.
    if (w_retry) begin
      if (try_q == c_max_try) begin
        food_x_d     = c_def_x;
        food_y_d     = c_def_y;
        food_valid_d = 1'b1;
        done_d       = 1'b1;
        fail_d       = 1'b1;
        state_d      = ST_IDLE;
      end else begin
        try_d   = try_q + 5'd1;
        state_d = ST_SX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      x_cand_q     <= '0;
      y_cand_q     <= '0;
      try_q        <= '0;
      occ_req_q    <= 1'b0;
      occ_x_q      <= '0;
      occ_y_q      <= '0;
      food_x_q     <= c_def_x;
      food_y_q     <= c_def_y;
      food_valid_q <= 1'b1;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_cand_q     <= x_cand_d;
      y_cand_q     <= y_cand_d;
      try_q        <= try_d;
      occ_req_q    <= occ_req_d;
      occ_x_q      <= occ_x_d;
      occ_y_q      <= occ_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
    end
  end

  assign occ_req    = occ_req_q;
  assign occ_x      = occ_x_q;
  assign occ_y      = occ_y_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign fail       = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_food_place_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_food_place_ctrl
// Description : Self-checking bench for food_place_ctrl. Expected commits are
//               queued as each scenario is driven and compared whenever the
//               design pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_food_place_ctrl;

  logic       clk;
  logic       rst_n;
  logic       eat;
  logic [8:0] rand_num;
  logic       occ_req;
  logic [9:0] occ_x;
  logic [8:0] occ_y;
  logic       occ_ack;
  logic       occ_hit;
  logic [9:0] food_x;
  logic [8:0] food_y;
  logic       food_valid;
  logic       busy;
  logic       done;
  logic       fail;

  food_place_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .eat        (eat),
    .rand_num   (rand_num),
    .occ_req    (occ_req),
    .occ_x      (occ_x),
    .occ_y      (occ_y),
    .occ_ack    (occ_ack),
    .occ_hit    (occ_hit),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .busy       (busy),
    .done       (done),
    .fail       (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int f;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference snapping: x doubles the 9-bit sample, both snap to 8 px.
  function automatic int ref_x(input int r);
    return ((r * 2) / 8) * 8;
  endfunction
  function automatic int ref_y(input int r);
    return (r / 8) * 8;
  endfunction

  function automatic exp_t mk(input int x, input int y, input int f);
    exp_t e;
    e.x = x; e.y = y; e.f = f;
    return e;
  endfunction

  // Scoreboard side: every done pulse must match the oldest queued commit.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check_val("done_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("commit_x", food_x, e.x);
        check_val("commit_y", food_y, e.y);
        check_val("commit_fail", fail, e.f);
        check_val("commit_valid", food_valid, 1);
        check_val("commit_busy", busy, 0);
      end
    end
    if (rst_n && fail && !done) check_val("fail_without_done", fail, 0);
  end

  // Called right after an edge; pulses eat for the next edge, returns in SX.
  task automatic start_eat();
    eat = 1'b1;
    @(posedge clk); #1;
    eat = 1'b0;
  endtask

  // Entered while the DUT is in SX; returns while it is in CHK.
  task automatic sample_pair(input int rx, input int ry);
    rand_num = 9'(rx);
    @(posedge clk); #1;
    rand_num = 9'(ry);
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_val("idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int dc;
    rst_n    = 1'b0;
    eat      = 1'b0;
    rand_num = '0;
    occ_ack  = 1'b0;
    occ_hit  = 1'b0;
    repeat (3) @(negedge clk);

    // ---- reset values ----
    check_val("rst_food_x", food_x, 304);
    check_val("rst_food_y", food_y, 240);
    check_val("rst_valid", food_valid, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_occ_req", occ_req, 0);
    check_val("rst_done", done, 0);
    check_val("rst_fail", fail, 0);
    check_val("rst_occ_x", occ_x, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // ---- ack while no request is ignored ----
    occ_ack = 1'b1; occ_hit = 1'b0;
    step();
    occ_ack = 1'b0;
    @(negedge clk);
    check_val("stray_ack_busy", busy, 0);
    check_val("stray_ack_done", done, 0);
    @(posedge clk); #1;

    // ---- clean placement, ack in first QRY cycle ----
    start_eat();                                  // cycle 1: SX
    @(negedge clk);
    check_val("clean_busy", busy, 1);
    check_val("clean_valid_low", food_valid, 0);
    #4;
    sample_pair(100, 50);                          // cycle 3: CHK
    @(negedge clk);
    check_val("clean_chk_noreq", occ_req, 0);
    #4;
    step();                                        // cycle 4: QRY
    @(negedge clk);
    check_val("clean_req", occ_req, 1);
    check_val("clean_occ_x", occ_x, ref_x(100));
    check_val("clean_occ_y", occ_y, ref_y(50));
    occ_ack = 1'b1; occ_hit = 1'b0;
    sb_q.push_back(mk(200, 48, 0));
    @(posedge clk); #1;                            // cycle 5: done
    occ_ack = 1'b0;
    @(negedge clk);
    check_val("clean_done_c5", done, 1);
    check_val("clean_req_drop", occ_req, 0);
    @(posedge clk); #1;

    // ---- high bounds reject then accept ----
    start_eat();
    sample_pair(400, 10);                          // x 800 > 624
    @(negedge clk);
    check_val("bnd_chk_noreq", occ_req, 0);
    @(posedge clk); #1;                            // back in SX
    @(negedge clk);
    check_val("bnd_retry_noreq", occ_req, 0);
    check_val("bnd_retry_busy", busy, 1);
    check_val("bnd_valid_low", food_valid, 0);
    #4;
    sample_pair(60, 70);
    step();
    @(negedge clk);
    check_val("bnd_occ_x", occ_x, ref_x(60));
    check_val("bnd_occ_y", occ_y, ref_y(70));
    check_val("bnd_req", occ_req, 1);
    occ_ack = 1'b1; occ_hit = 1'b0;
    sb_q.push_back(mk(120, 64, 0));
    @(posedge clk); #1;
    occ_ack = 1'b0;
    wait_idle(10);

    // ---- low bound reject ----
    start_eat();
    sample_pair(2, 50);                            // x 0 < 8
    @(negedge clk);
    check_val("low_chk_noreq", occ_req, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("low_retry_noreq", occ_req, 0);
    #4;
    sample_pair(100, 50);
    step();
    occ_ack = 1'b1; occ_hit = 1'b0;
    sb_q.push_back(mk(200, 48, 0));
    step();
    occ_ack = 1'b0;
    wait_idle(10);

    // ---- occupancy hit after wait cycles, then clean second query ----
    start_eat();
    sample_pair(100, 50);
    step();                                        // QRY
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("hit_wait_req", occ_req, 1);
      check_val("hit_wait_x", occ_x, 200);
      check_val("hit_wait_y", occ_y, 48);
      @(posedge clk); #1;
    end
    occ_ack = 1'b1; occ_hit = 1'b1;
    step();                                        // SX again
    occ_ack = 1'b0; occ_hit = 1'b0;
    @(negedge clk);
    check_val("hit_req_drop", occ_req, 0);
    check_val("hit_no_done", done, 0);
    #4;
    sample_pair(60, 70);
    step();
    @(negedge clk);
    check_val("hit_second_x", occ_x, 120);
    occ_ack = 1'b1;
    sb_q.push_back(mk(120, 64, 0));
    @(posedge clk); #1;
    occ_ack = 1'b0;
    wait_idle(10);

    // ---- fallback after 32 rejections ----
    rand_num = 9'd511;                             // x 1016 always out of range
    sb_q.push_back(mk(304, 240, 1));
    start_eat();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 400);
    check_val("fb_latency", n, 97);
    check_val("fb_fail_with_done", fail, 1);
    @(posedge clk); #1;
    rand_num = '0;
    wait_idle(10);

    // ---- eat during SY ignored: exactly one done ----
    dc = done_cnt;
    start_eat();
    rand_num = 9'd100;
    step();                                        // SY
    rand_num = 9'd50;
    eat = 1'b1;
    step();                                        // CHK
    eat = 1'b0;
    step();                                        // QRY
    occ_ack = 1'b1;
    sb_q.push_back(mk(200, 48, 0));
    step();
    occ_ack = 1'b0;
    repeat (8) step();
    check_val("busy_eat_one_done", done_cnt - dc, 1);
    check_val("busy_eat_idle", busy, 0);

    // ---- reset mid-handshake ----
    start_eat();
    sample_pair(60, 70);
    step();
    @(negedge clk);
    check_val("rq_req_before", occ_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rq_req_async_drop", occ_req, 0);
    check_val("rq_busy", busy, 0);
    check_val("rq_food_x", food_x, 304);
    check_val("rq_food_y", food_y, 240);
    check_val("rq_valid", food_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rq_post_occ_x", occ_x, 0);
    check_val("rq_post_done", done, 0);
    check_val("rq_post_busy", busy, 0);
    repeat (3) step();

    check_val("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
